// File: rtl/memory_stage_pkg.sv
// Shared core types for the MEM stage: control bundle, memory enums, FSM
// states and the store byte-lane helper.
package memory_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IID_W   = 8;
    localparam int unsigned WMASK_W = XLEN / 8;

    typedef logic [IID_W-1:0] iidtype;

    typedef enum logic [1:0] {
        MEN_X = 2'd0,
        MEN_S = 2'd1,
        MEN_L = 2'd2
    } men_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_t;

    typedef struct packed {
        logic       rf_wen;
        logic [3:0] alu_fn;
        men_t       mem_wen;
        size_t      mem_size;
        logic       mem_sext;
    } ctrltype;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        WAIT_RESP  = 2'd2,
        DONE       = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    wdata;
        logic [WMASK_W-1:0] wmask;
    } lane_t;

    // Replicate store data across lanes and build the byte enables.
    function automatic lane_t store_lanes(size_t size, logic [1:0] off, logic [XLEN-1:0] rs2);
        lane_t l;
        case (size)
            SIZE_B: begin
                l.wdata = {4{rs2[7:0]}};
                l.wmask = 4'(4'b0001 << off);
            end
            SIZE_H: begin
                l.wdata = {2{rs2[15:0]}};
                l.wmask = 4'(4'b0011 << {off[1], 1'b0});
            end
            default: begin
                l.wdata = rs2;
                l.wmask = 4'hF;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/memory_stage_load_extend.sv
// Aligns a loaded word to the access offset and sign/zero-extends it.
import memory_stage_pkg::*;

module load_extend (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        sext,
    output logic [31:0] result
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    always_comb begin
        shamt   = 5'd0;
        shifted = 32'd0;
        result  = 32'd0;
        case (size)
            SIZE_B:  shamt = {offset, 3'b000};
            SIZE_H:  shamt = {offset[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        shifted = rdata >> shamt;
        case (size)
            SIZE_B:  result = sext ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'd0, shifted[7:0]};
            SIZE_H:  result = sext ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'd0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues loads/stores over a valid/ready port, stalls
// upstream until the access completes, and forwards results to write-back.
import memory_stage_pkg::*;

module memory_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_valid,
    input  logic [31:0]  mem_pc,
    input  logic [31:0]  mem_inst,
    input  iidtype       mem_inst_id,
    input  ctrltype      mem_ctrl,
    input  logic [31:0]  mem_alu_out,
    input  logic [31:0]  mem_rs2_data,
    output logic         dreq_valid,
    input  logic         dreq_ready,
    output logic         dreq_wen,
    output logic [31:0]  dreq_addr,
    output logic [31:0]  dreq_wdata,
    output logic [3:0]   dreq_wmask,
    input  logic         dresp_valid,
    input  logic [31:0]  dresp_rdata,
    output logic         mem_wb_valid,
    output logic [31:0]  mem_wb_pc,
    output logic [31:0]  mem_wb_inst,
    output iidtype       mem_wb_inst_id,
    output ctrltype      mem_wb_ctrl,
    output logic [31:0]  mem_wb_alu_out,
    output logic [31:0]  mem_wb_rdata,
    output logic         mem_stall_flg
);

    mem_state_t  state;
    logic        saved_done;
    iidtype      saved_inst_id;
    logic [31:0] rdata_q;

    logic        req_wen_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wmask_q;
    size_t       req_size_q;
    logic        req_sext_q;

    logic        is_mem;
    logic        is_store;
    logic        already_done;
    lane_t       lanes;
    logic [31:0] load_ext;

    assign is_mem       = mem_ctrl.mem_wen != MEN_X;
    assign is_store     = mem_ctrl.mem_wen == MEN_S;
    assign already_done = saved_done && (saved_inst_id == mem_inst_id);
    assign lanes        = store_lanes(mem_ctrl.mem_size, mem_alu_out[1:0], mem_rs2_data);

    load_extend u_load_extend (
        .rdata  (dresp_rdata),
        .offset (req_addr_q[1:0]),
        .size   (req_size_q),
        .sext   (req_sext_q),
        .result (load_ext)
    );

    // Request port: live inputs while idle, latched copy once the access is in flight.
    always_comb begin
        dreq_valid = 1'b0;
        dreq_wen   = req_wen_q;
        dreq_addr  = {req_addr_q[31:2], 2'b00};
        dreq_wdata = req_wdata_q;
        dreq_wmask = req_wmask_q;
        case (state)
            IDLE: begin
                dreq_valid = rst_n && mem_valid && is_mem && !already_done;
                dreq_wen   = is_store;
                dreq_addr  = {mem_alu_out[31:2], 2'b00};
                dreq_wdata = lanes.wdata;
                dreq_wmask = lanes.wmask;
            end
            WAIT_READY: dreq_valid = 1'b1;
            default:    dreq_valid = 1'b0;
        endcase
    end

    assign mem_stall_flg  = rst_n && mem_valid && is_mem && (state != DONE);
    assign mem_wb_valid   = rst_n && mem_valid && !mem_stall_flg;
    assign mem_wb_rdata   = (state == DONE && !req_wen_q) ? rdata_q : 32'd0;
    assign mem_wb_pc      = mem_pc;
    assign mem_wb_inst    = mem_inst;
    assign mem_wb_inst_id = mem_inst_id;
    assign mem_wb_ctrl    = mem_ctrl;
    assign mem_wb_alu_out = mem_alu_out;

    // Access FSM and request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            saved_done    <= 1'b0;
            saved_inst_id <= '0;
            rdata_q       <= 32'd0;
            req_wen_q     <= 1'b0;
            req_addr_q    <= 32'd0;
            req_wdata_q   <= 32'd0;
            req_wmask_q   <= 4'd0;
            req_size_q    <= SIZE_B;
            req_sext_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq_valid) begin
                        req_wen_q   <= is_store;
                        req_addr_q  <= mem_alu_out;
                        req_wdata_q <= lanes.wdata;
                        req_wmask_q <= lanes.wmask;
                        req_size_q  <= mem_ctrl.mem_size;
                        req_sext_q  <= mem_ctrl.mem_sext;
                        if (!dreq_ready)
                            state <= WAIT_READY;
                        else if (is_store)
                            state <= DONE;
                        else
                            state <= WAIT_RESP;
                    end
                end
                WAIT_READY: begin
                    if (dreq_ready)
                        state <= req_wen_q ? DONE : WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (dresp_valid) begin
                        rdata_q <= load_ext;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    saved_done    <= 1'b1;
                    saved_inst_id <= mem_inst_id;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The instruction must stay put while its access is outstanding.
    a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WAIT_READY || state == WAIT_RESP) |-> mem_valid);

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: table of single accesses plus hand-written
// duplicate-guard and reset-during-access sequences.
import memory_stage_pkg::*;

module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    iidtype      mem_inst_id;
    ctrltype     mem_ctrl;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_rs2_data;
    logic        dreq_valid;
    logic        dreq_ready;
    logic        dreq_wen;
    logic [31:0] dreq_addr;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_wmask;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;
    logic        mem_wb_valid;
    logic [31:0] mem_wb_pc;
    logic [31:0] mem_wb_inst;
    iidtype      mem_wb_inst_id;
    ctrltype     mem_wb_ctrl;
    logic [31:0] mem_wb_alu_out;
    logic [31:0] mem_wb_rdata;
    logic        mem_stall_flg;

    memory_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_inst       (mem_inst),
        .mem_inst_id    (mem_inst_id),
        .mem_ctrl       (mem_ctrl),
        .mem_alu_out    (mem_alu_out),
        .mem_rs2_data   (mem_rs2_data),
        .dreq_valid     (dreq_valid),
        .dreq_ready     (dreq_ready),
        .dreq_wen       (dreq_wen),
        .dreq_addr      (dreq_addr),
        .dreq_wdata     (dreq_wdata),
        .dreq_wmask     (dreq_wmask),
        .dresp_valid    (dresp_valid),
        .dresp_rdata    (dresp_rdata),
        .mem_wb_valid   (mem_wb_valid),
        .mem_wb_pc      (mem_wb_pc),
        .mem_wb_inst    (mem_wb_inst),
        .mem_wb_inst_id (mem_wb_inst_id),
        .mem_wb_ctrl    (mem_wb_ctrl),
        .mem_wb_alu_out (mem_wb_alu_out),
        .mem_wb_rdata   (mem_wb_rdata),
        .mem_stall_flg  (mem_stall_flg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        men_t        wen;
        size_t       size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t   vecs [12];
    int     n_vec;
    int     n_err;
    iidtype id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input iidtype iid);
        mem_valid         = 1'b1;
        mem_inst_id       = iid;
        mem_pc            = 32'h100 + 32'(iid) * 32'd4;
        mem_inst          = 32'h0000_0013 + 32'(iid);
        mem_ctrl.rf_wen   = (v.wen != MEN_S);
        mem_ctrl.alu_fn   = 4'd0;
        mem_ctrl.mem_wen  = v.wen;
        mem_ctrl.mem_size = v.size;
        mem_ctrl.mem_sext = v.sext;
        mem_alu_out       = v.addr;
        mem_rs2_data      = v.rs2;
    endtask

    // Present one instruction at a negedge, act as the memory, check until it retires.
    task automatic run_access(input vec_t v, input iidtype iid);
        int   wait_left;
        int   stalls;
        int   hs;
        logic resp_now;
        logic resp_next;
        logic retired;
        wait_left = v.delay;
        stalls    = 0;
        hs        = 0;
        resp_now  = 1'b0;
        retired   = 1'b0;
        apply(v, iid);
        for (int cyc = 0; cyc < 40 && !retired; cyc++) begin
            dreq_ready  = (wait_left == 0);
            dresp_valid = resp_now;
            dresp_rdata = resp_now ? v.rdata : 32'h0BAD_0BAD;
            #1;
            resp_next = 1'b0;
            if (dreq_valid) begin
                chk({v.name, " addr"}, dreq_addr, v.exp_addr);
                chk({v.name, " wen"}, 32'(dreq_wen), 32'(v.wen == MEN_S));
                if (v.wen == MEN_S) begin
                    chk({v.name, " wdata"}, dreq_wdata, v.exp_wdata);
                    chk({v.name, " wmask"}, 32'(dreq_wmask), 32'(v.exp_wmask));
                end
                if (dreq_ready) begin
                    hs++;
                    resp_next = (v.wen == MEN_L);
                end else begin
                    wait_left--;
                end
            end
            if (mem_wb_valid) begin
                retired = 1'b1;
                chk({v.name, " rdata"}, mem_wb_rdata, v.exp_rd);
                chk({v.name, " stalls"}, 32'(stalls), 32'(v.exp_stall));
                chk({v.name, " handshakes"}, 32'(hs), (v.wen == MEN_X) ? 32'd0 : 32'd1);
                chk({v.name, " alu_out"}, mem_wb_alu_out, v.addr);
                chk({v.name, " inst_id"}, 32'(mem_wb_inst_id), 32'(iid));
            end else if (mem_stall_flg) begin
                stalls++;
            end
            @(negedge clk);
            resp_now = resp_next;
        end
        dreq_ready  = 1'b0;
        dresp_valid = 1'b0;
        if (!retired) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got no retire want retire within 40 cycles", v.name);
        end
    endtask

    initial begin
        vec_t lw_r;
        vec_t lb_r;
        n_vec        = 0;
        n_err        = 0;
        id           = '0;
        rst_n        = 1'b0;
        dreq_ready   = 1'b0;
        dresp_valid  = 1'b0;
        dresp_rdata  = 32'd0;

        //           name    wen    size    sx    addr          rs2           rdata         dly exp_addr      exp_wdata     mask     exp_rd        stall
        vecs[0]  = '{"alu",  MEN_X, SIZE_W, 1'b0, 32'h0000_1234, 32'h0,        32'h0,        0, 32'h0,        32'h0,        4'h0,    32'h0,        0};
        vecs[1]  = '{"sb",   MEN_S, SIZE_B, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0,       0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 32'h0,        1};
        vecs[2]  = '{"lh",   MEN_L, SIZE_H, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_0000, 0, 32'h0000_2000, 32'h0,        4'h0,    32'hFFFF_8001, 2};
        vecs[3]  = '{"lhu",  MEN_L, SIZE_H, 1'b0, 32'h0000_2002, 32'h0,        32'h8001_0000, 0, 32'h0000_2000, 32'h0,        4'h0,    32'h0000_8001, 2};
        vecs[4]  = '{"lw_d3", MEN_L, SIZE_W, 1'b1, 32'h0000_3004, 32'h0,       32'hDEAD_BEEF, 3, 32'h0000_3004, 32'h0,        4'h0,    32'hDEAD_BEEF, 5};
        vecs[5]  = '{"sh",   MEN_S, SIZE_H, 1'b0, 32'h0000_4003, 32'h1234_5678, 32'h0,       0, 32'h0000_4000, 32'h5678_5678, 4'b1100, 32'h0,        1};
        vecs[6]  = '{"sw",   MEN_S, SIZE_W, 1'b0, 32'h0000_5007, 32'hCAFE_F00D, 32'h0,       0, 32'h0000_5004, 32'hCAFE_F00D, 4'hF,    32'h0,        1};
        vecs[7]  = '{"lb",   MEN_L, SIZE_B, 1'b1, 32'h0000_6001, 32'h0,        32'h0000_8000, 0, 32'h0000_6000, 32'h0,        4'h0,    32'hFFFF_FF80, 2};
        vecs[8]  = '{"lbu",  MEN_L, SIZE_B, 1'b0, 32'h0000_6003, 32'h0,        32'h7F00_0000, 0, 32'h0000_6000, 32'h0,        4'h0,    32'h0000_007F, 2};
        vecs[9]  = '{"sb_d1", MEN_S, SIZE_B, 1'b0, 32'h0000_7002, 32'h0000_01FF, 32'h0,      1, 32'h0000_7000, 32'hFFFF_FFFF, 4'b0100, 32'h0,        2};
        vecs[10] = '{"lh_pos", MEN_L, SIZE_H, 1'b1, 32'h0000_2000, 32'h0,      32'h0000_7FFF, 0, 32'h0000_2000, 32'h0,        4'h0,    32'h0000_7FFF, 2};
        vecs[11] = '{"lw",   MEN_L, SIZE_W, 1'b0, 32'h0000_8000, 32'h0,        32'h1234_5678, 0, 32'h0000_8000, 32'h0,        4'h0,    32'h1234_5678, 2};

        // Reset state with a store presented: outputs must still be forced low.
        apply(vecs[1], id);
        dreq_ready = 1'b1;
        #12;
        chk("reset dreq_valid", 32'(dreq_valid), 32'd0);
        chk("reset stall", 32'(mem_stall_flg), 32'd0);
        chk("reset wb_valid", 32'(mem_wb_valid), 32'd0);
        chk("reset wb_rdata", mem_wb_rdata, 32'd0);
        @(negedge clk);
        mem_valid  = 1'b0;
        dreq_ready = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            id = id + 8'd1;
            run_access(vecs[i], id);
        end

        // Same instruction held after retirement must not re-issue.
        id = id + 8'd1;
        run_access(vecs[6], id);
        for (int k = 0; k < 2; k++) begin
            dreq_ready = 1'b1;
            #1;
            chk("dup dreq_valid", 32'(dreq_valid), 32'd0);
            chk("dup wb_valid", 32'(mem_wb_valid), 32'd0);
            @(negedge clk);
        end
        dreq_ready = 1'b0;

        // Reset while waiting for a load response.
        lw_r = vecs[11];
        lw_r.name = "lw_rst";
        id = id + 8'd1;
        apply(lw_r, id);
        dreq_ready = 1'b1;
        #1;
        chk("rst_seq issue", 32'(dreq_valid), 32'd1);
        @(negedge clk);
        dreq_ready = 1'b0;
        #1;
        chk("rst_seq wait_resp stall", 32'(mem_stall_flg), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_seq dreq_valid", 32'(dreq_valid), 32'd0);
        chk("rst_seq stall", 32'(mem_stall_flg), 32'd0);
        chk("rst_seq wb_valid", 32'(mem_wb_valid), 32'd0);
        chk("rst_seq wb_rdata", mem_wb_rdata, 32'd0);
        @(negedge clk);
        lb_r = vecs[7];
        lb_r.name = "lb_after_rst";
        id = id + 8'd1;
        apply(lb_r, id);
        rst_n = 1'b1;
        run_access(lb_r, id);

        mem_valid = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
